reg_file_sb: RTL and testbench

//  Parametrised multi-read register file with a write-back scoreboard and a sequential clear engine.
//  It is the next-generation register file for the pipelined core: 2 read ports, 1 write port,
//  and a per-register busy bit that is set at issue and cleared at write-back. The stage

---
 rtl/reg_file_sb_if.sv | 17 +
 rtl/reg_file_sb.sv | 58 +++++
 tb/tb_reg_file_sb.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read, write-back, issue and clear signals of the scoreboarded register file
interface reg_file_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic clear_req, ready, wr_en, issue_en, rd_busy1, rd_busy2;
   logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, issue_addr;
   logic [DATA_W-1:0] rd_data1, rd_data2, wr_data;
   modport master (
      output clear_req, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr,
      input  ready, rd_data1, rd_data2, rd_busy1, rd_busy2
   );
   modport slave (
      input  clear_req, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr,
      output ready, rd_data1, rd_data2, rd_busy1, rd_busy2
   );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with busy scoreboard and sequential clear engine
// RF_BYPASS_EN forwards an accepted write to a matching read port in the same cycle
module reg_file_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0
) (
   input logic clk,
   input logic rst,
   reg_file_sb_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic {CLEAR, IDLE} state_t;
   state_t state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic ready, wr_ok, iss_ok, z1, z2, byp1, byp2;
   assign ready  = state == IDLE;
   assign wr_ok  = ready && bus.wr_en && !bus.clear_req && !(ZERO_REG != 0 && bus.wr_addr == '0);
   assign iss_ok = ready && bus.issue_en && !bus.clear_req && !(ZERO_REG != 0 && bus.issue_addr == '0);
   assign z1     = ZERO_REG != 0 && bus.rd_addr1 == '0;
   assign z2     = ZERO_REG != 0 && bus.rd_addr2 == '0;
`ifdef RF_BYPASS_EN
   assign byp1 = wr_ok && bus.wr_addr == bus.rd_addr1;
   assign byp2 = wr_ok && bus.wr_addr == bus.rd_addr2;
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif
   assign bus.ready    = ready;
   assign bus.rd_data1 = !ready || z1 ? '0 : byp1 ? bus.wr_data : regs[bus.rd_addr1];
   assign bus.rd_data2 = !ready || z2 ? '0 : byp2 ? bus.wr_data : regs[bus.rd_addr2];
   assign bus.rd_busy1 = ready && !z1 && !byp1 && busy[bus.rd_addr1];
   assign bus.rd_busy2 = ready && !z2 && !byp2 && busy[bus.rd_addr2];
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
         busy  <= '0;
      end else if (state == CLEAR) begin
         regs[ptr] <= '0;
         ptr       <= ptr + 1'b1;
         if (&ptr) state <= IDLE;
      end else if (bus.clear_req) begin
         state <= CLEAR;
         ptr   <= '0;
         busy  <= '0;
      end else begin
         if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
            busy[bus.wr_addr] <= 1'b0;
         end
         // issue after write so a same-address issue leaves the register busy
         if (iss_ok) busy[bus.issue_addr] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard bench for reg_file_sb with ZERO_REG=0 and ZERO_REG=1 instances
module tb_reg_file_sb;
   logic clk = 1'b0, rst = 1'b1;
   int passed = 0, total = 0, fails = 0;
`ifdef RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct { string tag; int w; logic [15:0] d; logic busy; } exp_t;
   exp_t q[$];
   reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) ia ();
   reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) ib ();
   reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_a (.clk(clk), .rst(rst), .bus(ia));
   reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_b (.clk(clk), .rst(rst), .bus(ib));
   assign ib.clear_req  = ia.clear_req;
   assign ib.rd_addr1   = ia.rd_addr1;
   assign ib.rd_addr2   = ia.rd_addr2;
   assign ib.wr_en      = ia.wr_en;
   assign ib.wr_addr    = ia.wr_addr;
   assign ib.wr_data    = ia.wr_data;
   assign ib.issue_en   = ia.issue_en;
   assign ib.issue_addr = ia.issue_addr;
   always #5 clk = ~clk;
   task automatic chk(input string t, input logic [15:0] o, input logic [15:0] e);
      total++;
      assert (o === e) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
   endtask
   task automatic push(input string t, input int w, input logic [15:0] d, input logic bsy);
      q.push_back('{t, w, d, bsy});
   endtask
   task automatic drain();
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk({e.tag, "_data"}, e.w == 0 ? ia.rd_data1 : e.w == 1 ? ia.rd_data2 : e.w == 2 ? ib.rd_data1 : ib.rd_data2, e.d);
         chk({e.tag, "_busy"}, {15'd0, e.w == 0 ? ia.rd_busy1 : e.w == 1 ? ia.rd_busy2 : e.w == 2 ? ib.rd_busy1 : ib.rd_busy2}, {15'd0, e.busy});
      end
   endtask
   task automatic idle();
      ia.clear_req = 1'b0; ia.wr_en = 1'b0; ia.issue_en = 1'b0;
      ia.wr_addr = '0; ia.wr_data = '0; ia.issue_addr = '0;
   endtask
   task automatic go(input logic [2:0] a1, input logic [2:0] a2);
      @(negedge clk);
      idle();
      ia.rd_addr1 = a1;
      ia.rd_addr2 = a2;
   endtask
   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      ia.wr_en = 1'b1; ia.wr_addr = a; ia.wr_data = d;
   endtask
   task automatic iss(input logic [2:0] a);
      ia.issue_en = 1'b1; ia.issue_addr = a;
   endtask
   task automatic wait_clear(input string t);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk({t, "_ready_low"}, {15'd0, ia.ready}, 16'd0);
         chk({t, "_ready_low_z"}, {15'd0, ib.ready}, 16'd0);
         push({t, "_clr_rd"}, 0, 16'h0000, 1'b0);
         drain();
         go(3'd7, 3'd0);
      end
      #1;
      chk({t, "_ready_high"}, {15'd0, ia.ready}, 16'd1);
      chk({t, "_ready_high_z"}, {15'd0, ib.ready}, 16'd1);
   endtask
   task automatic read_all_zero(input string t);
      for (int i = 0; i < 8; i++) begin
         go(3'(i), 3'(7 - i));
         #1;
         for (int w = 0; w < 4; w++) push(t, w, 16'h0000, 1'b0);
         drain();
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      idle();
      ia.rd_addr1 = 3'd7;
      ia.rd_addr2 = 3'd0;
      @(negedge clk);
      rst = 1'b0;
      wr(3'd1, 16'h5555);
      iss(3'd1);
      wait_clear("t1");
      read_all_zero("t1_rd");
      go(3'd3, 3'd3); iss(3'd3); #1;
      push("t2_pre", 0, 16'h0000, 1'b0); drain();
      go(3'd3, 3'd3); #1;
      push("t2_busy", 0, 16'h0000, 1'b1); push("t2_busy_z", 2, 16'h0000, 1'b1); drain();
      wr(3'd3, 16'hBEEF); #1;
      push("t2_wrcyc", 0, BYP ? 16'hBEEF : 16'h0000, !BYP); drain();
      go(3'd3, 3'd3); #1;
      push("t2_post", 0, 16'hBEEF, 1'b0); push("t2_post_z", 2, 16'hBEEF, 1'b0); drain();
      go(3'd5, 3'd5); wr(3'd5, 16'h1234); #1;
      push("t3_same1", 0, BYP ? 16'h1234 : 16'h0000, 1'b0);
      push("t3_same2", 1, BYP ? 16'h1234 : 16'h0000, 1'b0); drain();
      go(3'd5, 3'd5); #1;
      push("t3_next", 0, 16'h1234, 1'b0); push("t3_next_z", 3, 16'h1234, 1'b0); drain();
      go(3'd2, 3'd3); iss(3'd2); wr(3'd2, 16'h00AA); #1;
      push("t4_cyc", 0, BYP ? 16'h00AA : 16'h0000, 1'b0); push("t4_other", 1, 16'hBEEF, 1'b0); drain();
      go(3'd2, 3'd2); #1;
      push("t4_after", 0, 16'h00AA, 1'b1); push("t4_after_z", 2, 16'h00AA, 1'b1); drain();
      go(3'd2, 3'd2); iss(3'd2); #1;
      go(3'd2, 3'd2); #1;
      push("t4_reissue", 1, 16'h00AA, 1'b1); drain();
      wr(3'd2, 16'h00BB); #1;
      push("t4_wb_cyc", 0, BYP ? 16'h00BB : 16'h00AA, !BYP); drain();
      go(3'd2, 3'd2); #1;
      push("t4_wb_after", 0, 16'h00BB, 1'b0); drain();
      go(3'd0, 3'd0); iss(3'd0); #1;
      push("t6_pre", 0, 16'h0000, 1'b0); push("t6_pre_z", 2, 16'h0000, 1'b0); drain();
      go(3'd0, 3'd0); #1;
      push("t6_busy", 0, 16'h0000, 1'b1); push("t6_busy_z", 2, 16'h0000, 1'b0); drain();
      wr(3'd0, 16'hFFFF); #1;
      push("t6_wrcyc", 0, BYP ? 16'hFFFF : 16'h0000, !BYP); push("t6_wrcyc_z", 2, 16'h0000, 1'b0); drain();
      go(3'd0, 3'd0); #1;
      push("t6_post", 0, 16'hFFFF, 1'b0); push("t6_post_z1", 2, 16'h0000, 1'b0);
      push("t6_post_z2", 3, 16'h0000, 1'b0); drain();
      for (int i = 0; i < 8; i++) begin
         go(3'(i), 3'(i));
         wr(3'(i), 16'h1100 + 16'(i));
      end
      go(3'd6, 3'd7); iss(3'd6);
      go(3'd6, 3'd7); #1;
      push("t5_fill6", 0, 16'h1106, 1'b1); push("t5_fill7", 1, 16'h1107, 1'b0);
      push("t5_fill6_z", 2, 16'h1106, 1'b1); drain();
      go(3'd1, 3'd4); ia.clear_req = 1'b1; wr(3'd1, 16'hDEAD); iss(3'd4); #1;
      chk("t5_req_ready", {15'd0, ia.ready}, 16'd1);
      push("t5_req_rd", 1, 16'h1104, 1'b0); drain();
      for (int i = 0; i < 4; i++) begin
         go(3'd7, 3'd6); #1;
         chk("t5_clr_ready", {15'd0, ia.ready}, 16'd0);
         push("t5_clr_rd", 0, 16'h0000, 1'b0); push("t5_clr_rd2", 1, 16'h0000, 1'b0); drain();
      end
      go(3'd7, 3'd6); rst = 1'b1; #1;
      chk("t5_rst_ready", {15'd0, ia.ready}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_clear("t5");
      read_all_zero("t5_rd");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
